array_adder: RTL and testbench



---
 rtl/array_adder_if.sv | 10 +
 rtl/array_adder.sv | 66 ++++++
 tb/tb_array_adder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/array_adder_if.sv
// Run/index/sum bundle for the array_adder engine.
// Master drives the step enable; slave presents the registered pointer and checksum.
interface array_adder_if;
    logic        run;
    logic [7:0]  index;
    logic [31:0] sum;

    modport master (output run, input index, sum);
    modport slave  (input run, output index, sum);
endinterface

// File: rtl/array_adder.sv
// In-place array-add engine B[i] <= A[i] + B[i] with running checksum; optional ARRAY_ADDER_ONESHOT_EN stops after one pass.
// Latency: one step per run=1 edge, visible on index/sum right after that edge.
// Backpressure: none; run=0 (or any non-1 value) holds all state, one step per run=1 cycle.
module array_adder (
    input  logic        clk,
    input  logic        rst_n,
    array_adder_if.slave bus
);
    logic [31:0] w_a [256];
    logic [31:0] w_b [256];
    logic [7:0]  r_index;
    logic [31:0] r_sum;
    logic        w_step;
    logic [31:0] w_t;

`ifdef ARRAY_ADDER_ONESHOT_EN
    logic r_done;
    assign w_step = (bus.run == 1'b1) && !r_done;
`else
    assign w_step = (bus.run == 1'b1);
`endif

    assign w_t = w_a[r_index] + w_b[r_index];

    // Each entry is its own register so reset can restore the seed pattern mid-run.
    for (genvar g = 0; g < 256; g++) begin : g_entry
        logic [31:0] r_a;
        logic [31:0] r_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a <= 32'(g);
                r_b <= 32'(g) << 16;
            end else if (w_step && (r_index == 8'(g))) begin
                r_b <= w_t;
            end
        end

        assign w_a[g] = r_a;
        assign w_b[g] = r_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= 8'd0;
            r_sum   <= 32'd0;
`ifdef ARRAY_ADDER_ONESHOT_EN
            r_done  <= 1'b0;
`endif
        end else if (w_step) begin
            r_sum <= r_sum + w_t;
`ifdef ARRAY_ADDER_ONESHOT_EN
            // Last entry latches done and parks the pointer instead of wrapping.
            if (r_index == 8'hFF)
                r_done <= 1'b1;
            else
                r_index <= r_index + 8'd1;
`else
            r_index <= r_index + 8'd1;
`endif
        end
    end

    assign bus.index = r_index;
    assign bus.sum   = r_sum;
endmodule

// File: tb/tb_array_adder.sv
// Scoreboard bench for array_adder: reference model pushes expected index/sum per edge, monitor pops and compares.
module tb_array_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    array_adder_if bus ();

    array_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] sum;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_a [256];
    logic [31:0] m_b [256];
    logic [7:0]  m_idx;
    logic [31:0] m_sum;
    logic        m_done;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_a[i] = 32'(i);
            m_b[i] = 32'(i) << 16;
        end
        m_idx  = 8'd0;
        m_sum  = 32'd0;
        m_done = 1'b0;
    endfunction

    function automatic void model_step();
        logic [31:0] t;
        if (m_done) return;
        t = m_a[m_idx] + m_b[m_idx];
        m_b[m_idx] = t;
        m_sum = m_sum + t;
`ifdef ARRAY_ADDER_ONESHOT_EN
        if (m_idx == 8'd255) m_done = 1'b1;
        else m_idx = m_idx + 8'd1;
`else
        m_idx = m_idx + 8'd1;
`endif
    endfunction

    // Reference model: one expected output per clock edge out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (bus.run === 1'b1) model_step();
                e.idx = m_idx;
                e.sum = m_sum;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_index", 32'(bus.index), 32'(e.idx));
                check("sb_sum", bus.sum, e.sum);
            end
        end
    end

    task automatic run_cycles(input int n, input logic r);
        repeat (n) begin
            bus.run = r;
            @(negedge clk);
        end
        bus.run = 1'b0;
    endtask

    // Asserts reset between edges and checks the asynchronous clear before any clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_index_async", 32'(bus.index), 32'd0);
        check("rst_sum_async", bus.sum, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] idx, input logic [31:0] sum);
        check({name, "_index"}, 32'(bus.index), 32'(idx));
        check({name, "_sum"}, bus.sum, sum);
    endtask

    initial begin
        bus.run = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        expect_out("reset", 8'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_cycles(10, 1'b0);
        expect_out("idle10", 8'd0, 32'd0);

        run_cycles(2, 1'b1);
        expect_out("run2", 8'd2, 32'h0001_0001);

`ifdef ARRAY_ADDER_ONESHOT_EN
        do_reset();
        run_cycles(256, 1'b1);
        expect_out("oneshot256", 8'd255, 32'h7F80_7F80);
        run_cycles(44, 1'b1);
        expect_out("oneshot300", 8'd255, 32'h7F80_7F80);
`else
        do_reset();
        run_cycles(255, 1'b1);
        expect_out("run255", 8'd255, 32'h7F80_7F80 - 32'd255 * 32'h0001_0001);
        run_cycles(1, 1'b1);
        expect_out("run256", 8'd0, 32'h7F80_7F80);

        do_reset();
        run_cycles(512, 1'b1);
        expect_out("run512", 8'd0, 32'hFF01_7E80);
`endif

        do_reset();
        run_cycles(10, 1'b1);
        run_cycles(5, 1'b0);
        run_cycles(10, 1'b1);
        expect_out("gap20", 8'd20, 32'h00BE_00BE);
        do_reset();
        run_cycles(10, 1'b1);
        expect_out("after_rst10", 8'd10, 32'h002D_002D);

        // Randomized run patterns, with resets sprinkled in, against the model.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 900; c++) begin
                bus.run = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            bus.run = 1'b0;
            expect_out("rand_blk", m_idx, m_sum);
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
